// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: PC width, 2-bit counter encodings and BTB entry layout.
// Latency: n/a (types and one pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int XLEN = 32;

  // 2-bit saturating direction counter; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // Tag is kept XLEN wide and holds pc >> (IDX_W+2); the upper IDX_W+2 bits
  // are therefore always zero and drop out in synthesis. This keeps the entry
  // layout independent of the BTB depth.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
    ctr_e            ctr;
  } btb_entry_t;

  // Saturating step of the direction counter towards the resolved outcome.
  function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
    logic [1:0] v;
    v = cur;
    if (taken && (v != 2'd3)) begin
      v = v + 2'd1;
    end else if (!taken && (v != 2'd0)) begin
      v = v - 2'd1;
    end
    return ctr_e'(v);
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer with one combinational lookup port and one synchronous update port.
// Latency: lookup is combinational from stored state; an update is visible from the cycle after its write edge.
// Backpressure: none; an update presented with i_wr_en is always absorbed at the next edge.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset (clears every valid bit)
//   i_rd_pc                 fetch PC to look up
//   o_rd_hit                valid entry with matching tag at i_rd_pc
//   o_rd_taken              o_rd_hit and counter predicts taken
//   o_rd_target             stored target of the hitting entry (meaningful only when o_rd_hit)
//   i_wr_en                 resolved branch/jal from EX (never jalr)
//   i_wr_pc                 PC of that instruction
//   i_wr_taken              resolved direction
//   i_wr_is_jal             selects strongly-taken initial counter on allocation
//   i_wr_target             resolved target
module btb #(
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_rd_pc,
  output logic            o_rd_hit,
  output logic            o_rd_taken,
  output logic [XLEN-1:0] o_rd_target,
  input  logic            i_wr_en,
  input  logic [XLEN-1:0] i_wr_pc,
  input  logic            i_wr_taken,
  input  logic            i_wr_is_jal,
  input  logic [XLEN-1:0] i_wr_target
);
  import cpu_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t r_mem [ENTRIES];

  // ---------------- lookup port ----------------
  logic [IDX_W-1:0] w_rd_idx;
  logic [XLEN-1:0]  w_rd_tag;
  btb_entry_t       w_rd_ent;

  assign w_rd_idx    = i_rd_pc[IDX_W+1:2];
  assign w_rd_tag    = i_rd_pc >> (IDX_W + 2);
  assign w_rd_ent    = r_mem[w_rd_idx];
  assign o_rd_hit    = w_rd_ent.valid && (w_rd_ent.tag == w_rd_tag);
  assign o_rd_taken  = o_rd_hit && w_rd_ent.ctr[1];
  assign o_rd_target = w_rd_ent.target;

  // ---------------- update port ----------------
  logic [IDX_W-1:0] w_wr_idx;
  logic [XLEN-1:0]  w_wr_tag;
  btb_entry_t       w_wr_ent;
  logic             w_wr_hit;
  btb_entry_t       w_wr_new;
  logic             w_wr_do;

  assign w_wr_idx = i_wr_pc[IDX_W+1:2];
  assign w_wr_tag = i_wr_pc >> (IDX_W + 2);
  assign w_wr_ent = r_mem[w_wr_idx];
  assign w_wr_hit = w_wr_ent.valid && (w_wr_ent.tag == w_wr_tag);

  always_comb begin
    w_wr_new = w_wr_ent;
    w_wr_do  = 1'b0;
    if (i_wr_en) begin
      if (w_wr_hit) begin
        // Train the existing entry; a not-taken outcome keeps the old target
        // so a later taken prediction still has a useful address.
        w_wr_do      = 1'b1;
        w_wr_new.ctr = ctr_step(w_wr_ent.ctr, i_wr_taken);
        if (i_wr_taken) begin
          w_wr_new.target = i_wr_target;
        end
      end else if (i_wr_taken) begin
        // Allocate over whatever aliased entry lives at this index.
        w_wr_do         = 1'b1;
        w_wr_new.valid  = 1'b1;
        w_wr_new.tag    = w_wr_tag;
        w_wr_new.target = i_wr_target;
        w_wr_new.ctr    = i_wr_is_jal ? ST : WT;
      end
    end
  end

  // Only valid bits are reset; tag/target/counter of an invalid entry are never looked at.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i].valid <= 1'b0;
      end
    end else if (w_wr_do) begin
      r_mem[w_wr_idx] <= w_wr_new;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch PC register with BTB-based next-PC prediction, EX misprediction redirect/flush and halt-address parking.
// Latency: pc_o registered (one edge per step); pred_*, flush_o, halted_o combinational from state and EX inputs.
// Backpressure: stall_i holds the PC; a mispredict redirect overrides stall and halt.
//
// Ports:
//   clk, rst_n                               clock, synchronous active-low reset
//   stall_i                                  hold PC (IF/ID stall)
//   pc_o                                     current fetch PC
//   pred_taken_o, pred_target_o              prediction for pc_o, carried down the pipe
//   ex_valid_i, ex_pc_i                      valid control-flow instruction in EX and its PC
//   ex_is_branch_i/ex_is_jal_i/ex_is_jalr_i  one-hot instruction class
//   ex_taken_i, ex_target_i                  resolved direction and target
//   ex_pred_taken_i, ex_pred_target_i        prediction made at fetch for that instruction
//   flush_o                                  kill IF/ID and ID/EX (high in the mispredict cycle)
//   halted_o                                 fetch parked at HALT_PC
module next_pc_predictor #(
  parameter int              XLEN        = cpu_pkg::XLEN,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter bit              HALT_EN     = 1'b1,
  parameter logic [XLEN-1:0] HALT_PC     = 'h94
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jal_i,
  input  logic            ex_is_jalr_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            flush_o,
  output logic            halted_o
);
  import cpu_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = 'd4;

  logic [XLEN-1:0] r_pc;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_ex_pc_plus4;
  logic            w_btb_hit;
  logic            w_btb_taken;
  logic [XLEN-1:0] w_btb_target;
  logic            w_btb_wr_en;
  logic            w_mispredict;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_next_pc;

  // Additions wrap modulo 2^XLEN by construction.
  assign w_pc_plus4    = r_pc + PC_STEP;
  assign w_ex_pc_plus4 = ex_pc_i + PC_STEP;

  // jalr targets depend on a register value, so they are never cached.
  assign w_btb_wr_en = ex_valid_i && (ex_is_branch_i || ex_is_jal_i) && !ex_is_jalr_i;

  btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_pc     (r_pc),
    .o_rd_hit    (w_btb_hit),
    .o_rd_taken  (w_btb_taken),
    .o_rd_target (w_btb_target),
    .i_wr_en     (w_btb_wr_en),
    .i_wr_pc     (ex_pc_i),
    .i_wr_taken  (ex_taken_i),
    .i_wr_is_jal (ex_is_jal_i),
    .i_wr_target (ex_target_i)
  );

  assign pc_o          = r_pc;
  assign pred_taken_o  = w_btb_taken;
  // A hit predicted not-taken still reports the stored target; the pipe only uses it when taken.
  assign pred_target_o = w_btb_hit ? w_btb_target : w_pc_plus4;

  // The target only matters when the instruction was actually taken.
  assign w_mispredict  = ex_valid_i &&
                         ((ex_taken_i != ex_pred_taken_i) ||
                          (ex_taken_i && (ex_target_i != ex_pred_target_i)));
  assign w_redirect_pc = ex_taken_i ? ex_target_i : w_ex_pc_plus4;
  assign flush_o       = w_mispredict;
  assign halted_o      = HALT_EN && (r_pc == HALT_PC);

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_mispredict) begin
      w_next_pc = w_redirect_pc;
    end else if (stall_i || halted_o) begin
      w_next_pc = r_pc;
    end else if (pred_taken_o) begin
      w_next_pc = pred_target_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
module tb_next_pc_predictor;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_is_branch_i;
  logic        ex_is_jal_i;
  logic        ex_is_jalr_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        flush_o;
  logic        halted_o;

  int errors = 0;
  int checks = 0;

  next_pc_predictor #(
    .XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .HALT_EN(1'b1), .HALT_PC(32'h94)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .pc_o(pc_o),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .ex_is_branch_i(ex_is_branch_i), .ex_is_jal_i(ex_is_jal_i), .ex_is_jalr_i(ex_is_jalr_i),
    .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .flush_o(flush_o), .halted_o(halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic        m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == (a / 64));
  endfunction

  function automatic logic e_pred_taken();
    return m_hit(m_pc) && (m_ctr[m_idx(m_pc)] >= 2);
  endfunction

  function automatic logic [31:0] e_pred_target();
    logic [31:0] nxt;
    nxt = m_pc + 32'd4;
    return m_hit(m_pc) ? m_tgt[m_idx(m_pc)] : nxt;
  endfunction

  function automatic logic e_mispredict();
    if (!ex_valid_i) return 1'b0;
    if (ex_taken_i != ex_pred_taken_i) return 1'b1;
    return ex_taken_i && (ex_target_i != ex_pred_target_i);
  endfunction

  function automatic logic e_halted();
    return m_pc == 32'h94;
  endfunction

  task automatic model_update();
    logic [31:0] nxt;
    int i;
    if (!rst_n) begin
      m_pc = 32'h0;
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
      return;
    end
    if (e_mispredict())       nxt = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
    else if (stall_i)         nxt = m_pc;
    else if (e_halted())      nxt = m_pc;
    else if (e_pred_taken())  nxt = e_pred_target();
    else                      nxt = m_pc + 32'd4;
    if (ex_valid_i && (ex_is_branch_i || ex_is_jal_i)) begin
      i = m_idx(ex_pc_i);
      if (m_hit(ex_pc_i)) begin
        if (ex_taken_i) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = ex_target_i;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ex_taken_i) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = ex_pc_i / 64;
        m_tgt[i]   = ex_target_i;
        m_ctr[i]   = ex_is_jal_i ? 3 : 2;
      end
    end
    m_pc = nxt;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // kind: 0 = branch, 1 = jal, 2 = jalr
  task automatic set_ex(input int kind, input logic [31:0] pc, input logic taken,
                        input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    ex_valid_i       = 1'b1;
    ex_is_branch_i   = (kind == 0);
    ex_is_jal_i      = (kind == 1);
    ex_is_jalr_i     = (kind == 2);
    ex_pc_i          = pc;
    ex_taken_i       = taken;
    ex_target_i      = tgt;
    ex_pred_taken_i  = ptaken;
    ex_pred_target_i = ptgt;
  endtask

  task automatic clear_ex();
    ex_valid_i = 1'b0; ex_is_branch_i = 1'b0; ex_is_jal_i = 1'b0; ex_is_jalr_i = 1'b0;
    ex_pc_i = '0; ex_taken_i = 1'b0; ex_target_i = '0;
    ex_pred_taken_i = 1'b0; ex_pred_target_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 1'b0; clear_ex();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush_o); end
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted_o); end
    checks++; if (pred_target_o !== 32'h4) begin errors++; $display("FAIL reset_pred_target: got %h want %h", pred_target_o, 32'h4); end
    tick();
  endtask

  task automatic test_seq_fetch();
    for (int k = 1; k <= 5; k++) begin
      settle();
      checks++; if (pc_o !== 32'(k * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", k, pc_o, 32'(k * 4)); end
      checks++; if (pred_taken_o !== 1'b0 || flush_o !== 1'b0) begin
        errors++; $display("FAIL seq_pred_flush[%0d]: got %b/%b want 0/0", k, pred_taken_o, flush_o); end
      tick();
    end
  endtask

  task automatic test_branch_train();
    set_ex(0, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    settle();
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL train_flush: got %b want 1", flush_o); end
    tick();
    set_ex(2, 32'h300, 1'b1, 32'h10, 1'b0, 32'h304);
    settle();
    checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL train_redirect_pc: got %h want %h", pc_o, 32'h40); end
    tick();
    clear_ex();
    settle();
    checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL train_refetch_pc: got %h want %h", pc_o, 32'h10); end
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL train_pred_taken: got %b want 1", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h40) begin errors++; $display("FAIL train_pred_target: got %h want %h", pred_target_o, 32'h40); end
    tick();
    settle();
    checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL train_follow_pred: got %h want %h", pc_o, 32'h40); end
    tick();
  endtask

  task automatic test_not_taken();
    set_ex(0, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
    settle();
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL nt1_flush: got %b want 1", flush_o); end
    tick();
    set_ex(0, 32'h10, 1'b0, 32'h40, 1'b0, 32'h14);
    settle();
    checks++; if (pc_o !== 32'h14) begin errors++; $display("FAIL nt1_redirect_pc: got %h want %h", pc_o, 32'h14); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL nt2_flush: got %b want 0", flush_o); end
    tick();
    set_ex(2, 32'h300, 1'b1, 32'h10, 1'b0, 32'h0);
    tick();
    clear_ex();
    settle();
    checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL nt_refetch_pc: got %h want %h", pc_o, 32'h10); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL nt_pred_taken: got %b want 0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h40) begin errors++; $display("FAIL nt_pred_target_hit: got %h want %h", pred_target_o, 32'h40); end
    tick();
  endtask

  task automatic test_alias();
    do_reset();
    set_ex(0, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    tick();
    set_ex(2, 32'h300, 1'b1, 32'h50, 1'b0, 32'h0);
    tick();
    clear_ex();
    settle();
    checks++; if (pc_o !== 32'h50) begin errors++; $display("FAIL alias_pc: got %h want %h", pc_o, 32'h50); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL alias_pred_taken: got %b want 0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h54) begin errors++; $display("FAIL alias_pred_target: got %h want %h", pred_target_o, 32'h54); end
    set_ex(2, 32'h300, 1'b1, 32'h10, 1'b0, 32'h0);
    tick();
    clear_ex();
    settle();
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL alias_orig_hit: got %b want 1", pred_taken_o); end
    tick();
  endtask

  task automatic test_write_visibility();
    set_ex(2, 32'h300, 1'b1, 32'h20, 1'b0, 32'h0);
    tick();
    set_ex(1, 32'h20, 1'b1, 32'h80, 1'b0, 32'h24);
    settle();
    checks++; if (pc_o !== 32'h20 || pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL wr_same_cycle: got pc %h pred %b want pc %h pred 0", pc_o, pred_taken_o, 32'h20); end
    tick();
    set_ex(2, 32'h300, 1'b1, 32'h20, 1'b0, 32'h0);
    settle();
    checks++; if (pc_o !== 32'h80) begin errors++; $display("FAIL wr_redirect_pc: got %h want %h", pc_o, 32'h80); end
    tick();
    clear_ex();
    settle();
    checks++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h80) begin
      errors++; $display("FAIL wr_visible: got %b/%h want 1/%h", pred_taken_o, pred_target_o, 32'h80); end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    clear_ex();
    stall_i = 1'b1;
    settle();
    held = pc_o;
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      checks++; if (pc_o !== held) begin errors++; $display("FAIL stall_hold[%0d]: got %h want %h", k, pc_o, held); end
    end
    set_ex(2, 32'h100, 1'b1, 32'h88, 1'b0, 32'h0);
    tick();
    clear_ex();
    settle();
    checks++; if (pc_o !== 32'h88) begin errors++; $display("FAIL stall_flush_pc: got %h want %h", pc_o, 32'h88); end
    stall_i = 1'b0;
    tick();
  endtask

  task automatic test_halt();
    bit reached;
    do_reset();
    reached = 1'b0;
    for (int k = 0; k < 80 && !reached; k++) begin
      settle();
      if (pc_o == 32'h94) reached = 1'b1;
      else tick();
    end
    checks++; if (!reached) begin errors++; $display("FAIL halt_reach: pc %h never reached %h", pc_o, 32'h94); end
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted_o); end
    for (int k = 0; k < 10; k++) tick();
    settle();
    checks++; if (pc_o !== 32'h94 || halted_o !== 1'b1) begin
      errors++; $display("FAIL halt_park: got %h/%b want %h/1", pc_o, halted_o, 32'h94); end
    set_ex(2, 32'h94, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL halt_exit_flush: got %b want 1", flush_o); end
    tick();
    clear_ex();
    settle();
    checks++; if (pc_o !== 32'h200 || halted_o !== 1'b0) begin
      errors++; $display("FAIL halt_exit: got %h/%b want %h/0", pc_o, halted_o, 32'h200); end
    tick();
  endtask

  task automatic test_wrap();
    set_ex(2, 32'h300, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick();
    clear_ex();
    settle();
    checks++; if (pc_o !== 32'hFFFF_FFFC || pred_target_o !== 32'h0) begin
      errors++; $display("FAIL wrap_top: got %h/%h want %h/%h", pc_o, pred_target_o, 32'hFFFF_FFFC, 32'h0); end
    tick();
    settle();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want %h", pc_o, 32'h0); end
    tick();
  endtask

  task automatic test_reset_mid();
    stall_i = 1'b1;
    set_ex(2, 32'h100, 1'b1, 32'h300, 1'b0, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; stall_i = 1'b0; clear_ex();
    settle();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_mid_pc: got %h want %h", pc_o, 32'h0); end
    tick();
  endtask

  task automatic test_random();
    int kind;
    logic tk;
    logic [31:0] tg;
    int bad;
    bad = 0;
    for (int n = 0; n < 500; n++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      stall_i = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) begin
        kind = $urandom_range(0, 2);
        tk   = (kind != 0) ? 1'b1 : 1'($urandom_range(0, 1));
        tg   = 32'($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 1) == 1)
          set_ex(kind, 32'($urandom_range(0, 63) * 4), tk, tg, tk, tg);
        else
          set_ex(kind, 32'($urandom_range(0, 63) * 4), tk, tg, 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 63) * 4));
      end else begin
        clear_ex();
      end
      settle();
      checks++;
      if (pc_o !== m_pc || pred_taken_o !== e_pred_taken() || pred_target_o !== e_pred_target() ||
          flush_o !== e_mispredict() || halted_o !== e_halted()) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: got pc %h pt %b tgt %h fl %b h %b want pc %h pt %b tgt %h fl %b h %b",
                   n, pc_o, pred_taken_o, pred_target_o, flush_o, halted_o,
                   m_pc, e_pred_taken(), e_pred_target(), e_mispredict(), e_halted());
        bad++;
      end
      tick();
    end
    rst_n = 1'b1; stall_i = 1'b0; clear_ex();
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; clear_ex();
    m_pc = 32'h0;
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 0;
    end
    #1;
    test_reset();
    test_seq_fetch();
    test_branch_train();
    test_not_taken();
    test_alias();
    test_write_visibility();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_mid();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
